// File: rtl/bp_stall_profiler_ctrl.sv
// bp_stall_profiler_ctrl: stall-profiling counter bank with live/shadow counters and a host command FSM
// Ports: clk_i/reset_i (async active-high); en_i, commit_v_i, stall_v_i, stall_reason_i from the
// commit/stall monitor; req_v_i/req_ready_o/req_op_i/req_addr_i host command (0 READ, 1 SNAP,
// 2 CLEAR, 3 NOP); resp_v_o/resp_ready_i/resp_data_o host response; busy_o high outside IDLE.
// Address map: 0..num_reasons_p-1 reason counters, num_reasons_p cycles, num_reasons_p+1 commits.
// Build option BP_PROFILER_SATURATE_EN: live counters saturate at all-ones instead of wrapping.
module bp_stall_profiler_ctrl #(
    parameter int num_reasons_p = 33,
    parameter int ctr_width_p   = 64,
    parameter int addr_width_p  = 6
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic                     en_i,
    input  logic                     commit_v_i,
    input  logic                     stall_v_i,
    input  logic [num_reasons_p-1:0] stall_reason_i,
    input  logic                     req_v_i,
    output logic                     req_ready_o,
    input  logic [1:0]               req_op_i,
    input  logic [addr_width_p-1:0]  req_addr_i,
    output logic                     resp_v_o,
    input  logic                     resp_ready_i,
    output logic [ctr_width_p-1:0]   resp_data_o,
    output logic                     busy_o
);
    localparam int n_ctr_lp = num_reasons_p + 2;
    localparam int idx_w_lp = $clog2(n_ctr_lp);
    localparam logic [idx_w_lp-1:0] cyc_idx_lp = idx_w_lp'(num_reasons_p);
    localparam logic [idx_w_lp-1:0] cmt_idx_lp = idx_w_lp'(num_reasons_p + 1);
    localparam logic [1:0] op_read_lp  = 2'd0;
    localparam logic [1:0] op_snap_lp  = 2'd1;
    localparam logic [1:0] op_clear_lp = 2'd2;

    typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_RESP} state_e;

    state_e                 state_q, state_d;
    logic [idx_w_lp-1:0]    idx_q, idx_d;
    logic [ctr_width_p-1:0] resp_data_q, resp_data_d;
    logic [ctr_width_p-1:0] live_q [n_ctr_lp];
    logic [ctr_width_p-1:0] live_d [n_ctr_lp];
    logic [ctr_width_p-1:0] shadow_q [n_ctr_lp];
    logic [ctr_width_p-1:0] shadow_d [n_ctr_lp];
    logic                   cyc_q, cmt_q, stl_q;
    logic [idx_w_lp-1:0]    rsn_q, rsn_hi;
    logic                   in_clear, sample, accept, rd_ok;

    function automatic logic [ctr_width_p-1:0] bump(input logic [ctr_width_p-1:0] v);
`ifdef BP_PROFILER_SATURATE_EN
        return (&v) ? v : v + ctr_width_p'(1);
`else
        return v + ctr_width_p'(1);
`endif
    endfunction

    assign in_clear    = (state_q == S_CLEAR);
    assign sample      = en_i & ~in_clear;
    assign accept      = req_v_i & (state_q == S_IDLE);
    assign rd_ok       = (req_op_i == op_read_lp) && (req_addr_i < addr_width_p'(n_ctr_lp));
    assign req_ready_o = (state_q == S_IDLE);
    assign resp_v_o    = (state_q == S_RESP);
    assign busy_o      = (state_q != S_IDLE);
    assign resp_data_o = resp_data_q;

    // Highest set reason bit wins; an empty vector falls through to reason 0 (unknown)
    always_comb begin
        rsn_hi = '0;
        for (int i = 0; i < num_reasons_p; i++)
            if (stall_reason_i[i]) rsn_hi = idx_w_lp'(i);
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            cyc_q <= 1'b0;
            cmt_q <= 1'b0;
            stl_q <= 1'b0;
            rsn_q <= '0;
        end else begin
            cyc_q <= sample;
            cmt_q <= sample & commit_v_i;
            stl_q <= sample & ~commit_v_i & stall_v_i;
            rsn_q <= rsn_hi;
        end
    end

    // Snapshot copies live_q, i.e. the values before this edge's pending increment lands
    always_comb begin
        live_d   = live_q;
        shadow_d = shadow_q;
        if (accept && req_op_i == op_snap_lp) shadow_d = live_q;
        if (in_clear) begin
            live_d[idx_q]   = '0;
            shadow_d[idx_q] = '0;
        end else begin
            if (cyc_q) live_d[cyc_idx_lp] = bump(live_q[cyc_idx_lp]);
            if (cmt_q) live_d[cmt_idx_lp] = bump(live_q[cmt_idx_lp]);
            if (stl_q) live_d[rsn_q] = bump(live_q[rsn_q]);
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            for (int i = 0; i < n_ctr_lp; i++) begin
                live_q[i]   <= '0;
                shadow_q[i] <= '0;
            end
        end else begin
            live_q   <= live_d;
            shadow_q <= shadow_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        resp_data_d = resp_data_q;
        case (state_q)
            S_IDLE: if (req_v_i) begin
                state_d     = (req_op_i == op_clear_lp) ? S_CLEAR : S_RESP;
                idx_d       = '0;
                resp_data_d = rd_ok ? shadow_q[idx_w_lp'(req_addr_i)] : '0;
            end
            S_CLEAR: begin
                idx_d = idx_q + idx_w_lp'(1);
                if (idx_q == cmt_idx_lp) begin
                    state_d     = S_RESP;
                    resp_data_d = ctr_width_p'(n_ctr_lp);
                end
            end
            S_RESP: if (resp_ready_i) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            resp_data_q <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            resp_data_q <= resp_data_d;
        end
    end
endmodule

// File: tb/tb_bp_stall_profiler_ctrl.sv
// tb_bp_stall_profiler_ctrl: randomized and directed checks against a counting reference model
module tb_bp_stall_profiler_ctrl;
    logic        clk = 1'b0;
    logic        reset_i = 1'b1;
    logic        en = 1'b0, commit_v = 1'b0, stall_v = 1'b0;
    logic [32:0] reason = '0;
    logic        req_v = 1'b0, resp_ready = 1'b0;
    logic [1:0]  req_op = 2'd0;
    logic [5:0]  req_addr = '0;
    logic        req_ready, resp_v, busy;
    logic [63:0] resp_data;
    logic        req_ready4, resp_v4, busy4;
    logic [3:0]  resp_data4;

    int total = 0;
    int passed = 0;
    longint unsigned live_m [35];
    longint unsigned shadow_m [35];
    bit pend_cyc = 1'b0;
    int pend_idx = -1;

    always #5 clk = ~clk;

    bp_stall_profiler_ctrl dut (
        .clk_i(clk), .reset_i(reset_i), .en_i(en), .commit_v_i(commit_v), .stall_v_i(stall_v),
        .stall_reason_i(reason), .req_v_i(req_v), .req_ready_o(req_ready), .req_op_i(req_op),
        .req_addr_i(req_addr), .resp_v_o(resp_v), .resp_ready_i(resp_ready),
        .resp_data_o(resp_data), .busy_o(busy)
    );

    bp_stall_profiler_ctrl #(.ctr_width_p(4)) dut4 (
        .clk_i(clk), .reset_i(reset_i), .en_i(en), .commit_v_i(commit_v), .stall_v_i(stall_v),
        .stall_reason_i(reason), .req_v_i(req_v), .req_ready_o(req_ready4), .req_op_i(req_op),
        .req_addr_i(req_addr), .resp_v_o(resp_v4), .resp_ready_i(resp_ready),
        .resp_data_o(resp_data4), .busy_o(busy4)
    );

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    function automatic longint unsigned bump(input longint unsigned v);
`ifdef BP_PROFILER_SATURATE_EN
        return (v == 64'hFFFF_FFFF_FFFF_FFFF) ? v : v + 1;
`else
        return v + 1;
`endif
    endfunction

    function automatic int top_reason(input logic [32:0] r);
        for (int i = 32; i >= 0; i--) if (r[i]) return i;
        return 0;
    endfunction

    task automatic model_zero();
        live_m   = '{default: 0};
        shadow_m = '{default: 0};
        pend_cyc = 1'b0;
        pend_idx = -1;
    endtask

    // One clock edge: snapshot sees counts before the edge, last cycle's attribution lands, new one samples
    task automatic tick();
        @(posedge clk);
        if (req_v && req_op == 2'd1) shadow_m = live_m;
        if (pend_cyc) live_m[33] = bump(live_m[33]);
        if (pend_idx >= 0) live_m[pend_idx] = bump(live_m[pend_idx]);
        pend_cyc = en;
        pend_idx = !en ? -1 : commit_v ? 34 : stall_v ? top_reason(reason) : -1;
        #1;
    endtask

    task automatic cmd(input logic [1:0] op, input logic [5:0] addr,
                       output logic [63:0] d, output logic [3:0] d4);
        int n = 0;
        req_v = 1'b1; req_op = op; req_addr = addr;
        tick();
        req_v = 1'b0;
        if (op == 2'd2) model_zero();
        while (resp_v !== 1'b1 && n < 100) begin tick(); n++; end
        d = resp_data;
        d4 = resp_data4;
        if (resp_v !== 1'b1) begin
            total++;
            $display("FAIL cmd_timeout op=%0d resp_v=%b expected 1", op, resp_v);
        end
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
    endtask

    task automatic idle_inputs();
        en = 1'b0; commit_v = 1'b0; stall_v = 1'b0; reason = '0;
        tick(); tick();
    endtask

    task automatic test_reset();
        logic [63:0] d; logic [3:0] d4;
        @(posedge clk); @(posedge clk); #1;
        total++; if (req_ready !== 1'b1) $display("FAIL rst_ready got=%b exp=1", req_ready); else passed++;
        total++; if (resp_v !== 1'b0) $display("FAIL rst_resp_v got=%b exp=0", resp_v); else passed++;
        total++; if (resp_data !== 64'd0) $display("FAIL rst_data got=%0d exp=0", resp_data); else passed++;
        total++; if (busy !== 1'b0) $display("FAIL rst_busy got=%b exp=0", busy); else passed++;
        @(negedge clk) reset_i = 1'b0;
        model_zero();
        tick();
        cmd(2'd0, 6'd33, d, d4);
        total++; if (d !== 64'd0) $display("FAIL rst_read33 got=%0d exp=0", d); else passed++;
    endtask

    task automatic test_width4();
        logic [63:0] d; logic [3:0] d4;
        logic [3:0] exp4;
`ifdef BP_PROFILER_SATURATE_EN
        exp4 = 4'd15;
`else
        exp4 = 4'd4;
`endif
        en = 1'b1; stall_v = 1'b1; reason = 33'd1 << 5;
        repeat (20) tick();
        idle_inputs();
        cmd(2'd1, 6'd0, d, d4);
        total++; if (d !== 64'd0) $display("FAIL snap_resp got=%0d exp=0", d); else passed++;
        cmd(2'd0, 6'd5, d, d4);
        total++; if (d4 !== exp4) $display("FAIL w4_read5 got=%0d exp=%0d", d4, exp4); else passed++;
        total++; if (d !== shadow_m[5]) $display("FAIL w64_read5 got=%0d exp=%0d", d, shadow_m[5]); else passed++;
    endtask

    task automatic test_stall_priority();
        logic [63:0] d; logic [3:0] d4;
        longint unsigned base32;
        base32 = live_m[32];
        en = 1'b1; stall_v = 1'b1; reason = (33'd1 << 32) | (33'd1 << 3);
        repeat (10) tick();
        idle_inputs();
        cmd(2'd1, 6'd0, d, d4);
        cmd(2'd0, 6'd32, d, d4);
        total++; if (d !== base32 + 10) $display("FAIL prio_read32 got=%0d exp=%0d", d, base32 + 10); else passed++;
        cmd(2'd0, 6'd3, d, d4);
        total++; if (d !== shadow_m[3]) $display("FAIL prio_read3 got=%0d exp=%0d", d, shadow_m[3]); else passed++;
        cmd(2'd0, 6'd33, d, d4);
        total++; if (d !== shadow_m[33]) $display("FAIL prio_read33 got=%0d exp=%0d", d, shadow_m[33]); else passed++;
    endtask

    task automatic test_commit_wins();
        logic [63:0] d; logic [3:0] d4;
        en = 1'b1; commit_v = 1'b1; stall_v = 1'b1; reason = 33'd1 << 20;
        repeat (5) tick();
        idle_inputs();
        cmd(2'd1, 6'd0, d, d4);
        cmd(2'd0, 6'd34, d, d4);
        total++; if (d !== 64'd5) $display("FAIL commit_read34 got=%0d exp=5", d); else passed++;
        cmd(2'd0, 6'd20, d, d4);
        total++; if (d !== 64'd0) $display("FAIL commit_read20 got=%0d exp=0", d); else passed++;
    endtask

    task automatic test_zero_vector();
        logic [63:0] d; logic [3:0] d4;
        en = 1'b1; stall_v = 1'b1; reason = '0;
        repeat (7) tick();
        idle_inputs();
        cmd(2'd1, 6'd0, d, d4);
        cmd(2'd0, 6'd0, d, d4);
        total++; if (d !== 64'd7) $display("FAIL zero_read0 got=%0d exp=7", d); else passed++;
        cmd(2'd0, 6'd40, d, d4);
        total++; if (d !== 64'd0) $display("FAIL read40 got=%0d exp=0", d); else passed++;
        cmd(2'd3, 6'd33, d, d4);
        total++; if (d !== 64'd0) $display("FAIL nop_resp got=%0d exp=0", d); else passed++;
    endtask

    task automatic test_snap_latency();
        logic [63:0] d; logic [3:0] d4;
        en = 1'b1; stall_v = 1'b1; reason = 33'd1 << 7;
        repeat (4) tick();
        cmd(2'd1, 6'd0, d, d4);
        cmd(2'd0, 6'd7, d, d4);
        total++; if (d !== shadow_m[7]) $display("FAIL lat_read7 got=%0d exp=%0d", d, shadow_m[7]); else passed++;
        cmd(2'd0, 6'd33, d, d4);
        total++; if (d !== shadow_m[33]) $display("FAIL lat_read33 got=%0d exp=%0d", d, shadow_m[33]); else passed++;
        idle_inputs();
    endtask

    task automatic test_random();
        logic [63:0] d; logic [3:0] d4;
        logic [5:0] a;
        longint unsigned exp;
        for (int k = 0; k < 240; k++) begin
            en = ($urandom_range(0, 7) != 0);
            commit_v = ($urandom_range(0, 3) == 0);
            stall_v = $urandom_range(0, 1);
            case ($urandom_range(0, 2))
                0: reason = '0;
                1: reason = 33'd1 << $urandom_range(0, 32);
                default: reason = {$urandom_range(0, 1) == 1, $urandom()};
            endcase
            tick();
            if (k % 20 == 19) begin
                cmd(2'd1, 6'd0, d, d4);
                a = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(35, 63)) : 6'($urandom_range(0, 34));
                exp = (a < 35) ? shadow_m[a] : 0;
                cmd(2'd0, a, d, d4);
                total++; if (d !== exp) $display("FAIL rand_read addr=%0d got=%0d exp=%0d", a, d, exp); else passed++;
            end
        end
        idle_inputs();
    endtask

    task automatic test_clear();
        logic [63:0] d; logic [3:0] d4;
        int n = 0;
        bit ready_seen = 1'b0;
        req_v = 1'b1; req_op = 2'd2;
        tick();
        req_v = 1'b0;
        model_zero();
        while (busy === 1'b1 && resp_v !== 1'b1 && n < 100) begin
            if (req_ready !== 1'b0) ready_seen = 1'b1;
            tick();
            n++;
        end
        total++; if (n != 35) $display("FAIL clear_cycles got=%0d exp=35", n); else passed++;
        total++; if (ready_seen) $display("FAIL clear_ready got=1 exp=0"); else passed++;
        for (int k = 0; k < 3; k++) begin
            total++; if (resp_v !== 1'b1) $display("FAIL clear_hold_v got=%b exp=1", resp_v); else passed++;
            total++; if (resp_data !== 64'd35) $display("FAIL clear_data got=%0d exp=35", resp_data); else passed++;
            total++; if (req_ready !== 1'b0) $display("FAIL clear_hold_ready got=%b exp=0", req_ready); else passed++;
            tick();
        end
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        total++; if (busy !== 1'b0) $display("FAIL clear_done_busy got=%b exp=0", busy); else passed++;
        cmd(2'd1, 6'd0, d, d4);
        cmd(2'd0, 6'd33, d, d4);
        total++; if (d !== 64'd0) $display("FAIL clear_read33 got=%0d exp=0", d); else passed++;
        cmd(2'd0, 6'd34, d, d4);
        total++; if (d !== 64'd0) $display("FAIL clear_read34 got=%0d exp=0", d); else passed++;
    endtask

    task automatic test_reset_mid_clear();
        logic [63:0] d; logic [3:0] d4;
        en = 1'b1; stall_v = 1'b1; reason = 33'd1 << 9;
        repeat (5) tick();
        idle_inputs();
        cmd(2'd1, 6'd0, d, d4);
        req_v = 1'b1; req_op = 2'd2;
        tick();
        req_v = 1'b0;
        repeat (10) tick();
        #1 reset_i = 1'b1;
        #1;
        total++; if (req_ready !== 1'b1) $display("FAIL mid_ready got=%b exp=1", req_ready); else passed++;
        total++; if (resp_v !== 1'b0) $display("FAIL mid_resp_v got=%b exp=0", resp_v); else passed++;
        total++; if (resp_data !== 64'd0) $display("FAIL mid_data got=%0d exp=0", resp_data); else passed++;
        total++; if (busy !== 1'b0) $display("FAIL mid_busy got=%b exp=0", busy); else passed++;
        model_zero();
        @(negedge clk) reset_i = 1'b0;
        tick();
        cmd(2'd0, 6'd33, d, d4);
        total++; if (d !== 64'd0) $display("FAIL mid_read33 got=%0d exp=0", d); else passed++;
        cmd(2'd0, 6'd9, d, d4);
        total++; if (d !== 64'd0) $display("FAIL mid_read9 got=%0d exp=0", d); else passed++;
    endtask

    initial begin
        model_zero();
        test_reset();
        test_width4();
        test_stall_priority();
        test_commit_wins();
        test_zero_vector();
        test_snap_latency();
        test_random();
        test_clear();
        test_reset_mid_clear();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
